// File: rtl/arm_pkg.sv
// Shared ARM-style definitions: condition codes, flag bit positions and the
// EXE/MEM control bundle with its gating helper.
package arm_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [31:0] RETIRE_MAX = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } ctrl_t;

  // A squashed or bubble slot must never write back or touch memory.
  function automatic ctrl_t gate_ctrl(input logic commit, input logic wb_en,
                                      input logic mem_r_en, input logic mem_w_en);
    ctrl_t c;
    c.valid    = commit;
    c.wb_en    = commit & wb_en;
    c.mem_r_en = commit & mem_r_en;
    c.mem_w_en = commit & mem_w_en;
    return c;
  endfunction

endpackage

// File: rtl/exe_mem_reg_if.sv
// EXE->MEM pipeline boundary: EXE-stage results and hazard controls in,
// registered MEM-stage fields, flags, condition result and retire count out.
interface exe_mem_reg_if;

  logic        valid_in;
  logic [31:0] alu_result;
  logic [3:0]  status_bits;
  logic        s_bit;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [3:0]  dest_in;
  logic [31:0] val_rm_in;
  logic        freeze;
  logic        flush;
  logic [3:0]  cond_in;

  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        valid_out;
  logic [31:0] alu_result_out;
  logic [31:0] val_rm_out;
  logic [3:0]  dest_out;
  logic [3:0]  status_reg;
  logic        carry_out;
  logic        cond_pass;
  logic [31:0] retire_cnt;

  modport master (
    output valid_in, alu_result, status_bits, s_bit, wb_en_in, mem_r_en_in,
           mem_w_en_in, dest_in, val_rm_in, freeze, flush, cond_in,
    input  wb_en, mem_r_en, mem_w_en, valid_out, alu_result_out, val_rm_out,
           dest_out, status_reg, carry_out, cond_pass, retire_cnt
  );

  modport slave (
    input  valid_in, alu_result, status_bits, s_bit, wb_en_in, mem_r_en_in,
           mem_w_en_in, dest_in, val_rm_in, freeze, flush, cond_in,
    output wb_en, mem_r_en, mem_w_en, valid_out, alu_result_out, val_rm_out,
           dest_out, status_reg, carry_out, cond_pass, retire_cnt
  );

endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator against a {N,Z,C,V} flag nibble.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic  n;
  logic  z;
  logic  c;
  logic  v;
  cond_e code;

  // Decode the condition field against the supplied flags.
  always_comb begin
    n    = flags[FLAG_N];
    z    = flags[FLAG_Z];
    c    = flags[FLAG_C];
    v    = flags[FLAG_V];
    code = cond_e'(cond);
    case (code)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register with the architectural flag register, a flag
// bypass for the ID-stage condition check, and a saturating retire counter.
module exe_mem_reg
  import arm_pkg::*;
(
  input logic          clk,
  input logic          rst,
  exe_mem_reg_if.slave bus
);

  logic        commit;
  logic        set_flags;
  logic [3:0]  flags_next;
  ctrl_t       ctrl;
  logic [31:0] alu_data;
  logic [31:0] rm_data;
  logic [3:0]  dest;
  logic [3:0]  flags;
  logic [31:0] retire;
  wire  [31:0] retire_nxt;

  // Commit qualification and next-state flags; the ID stage sees the flags
  // the current EXE instruction is about to write, so no bubble is needed.
  always_comb begin
    commit    = bus.valid_in & ~bus.freeze & ~bus.flush;
    set_flags = commit & bus.s_bit;
    if (set_flags) begin
      flags_next = bus.status_bits;
    end else begin
      flags_next = flags;
    end
  end

  assign retire_nxt = (commit && (retire != RETIRE_MAX)) ? (retire + 32'd1) : retire;

  cond_check u_cond_check (
    .cond  (bus.cond_in),
    .flags (flags_next),
    .pass  (bus.cond_pass)
  );

  // Pipeline, flag and retire state; freeze holds everything, including
  // over a simultaneous flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl     <= '0;
      alu_data <= 32'h0000_0000;
      rm_data  <= 32'h0000_0000;
      dest     <= 4'b0000;
      flags    <= 4'b0000;
      retire   <= 32'h0000_0000;
    end else if (!bus.freeze) begin
      ctrl     <= gate_ctrl(commit, bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in);
      alu_data <= bus.alu_result;
      rm_data  <= bus.val_rm_in;
      dest     <= bus.dest_in;
      flags    <= flags_next;
      retire   <= retire_nxt;
    end
  end

  assign bus.valid_out      = ctrl.valid;
  assign bus.wb_en          = ctrl.wb_en;
  assign bus.mem_r_en       = ctrl.mem_r_en;
  assign bus.mem_w_en       = ctrl.mem_w_en;
  assign bus.alu_result_out = alu_data;
  assign bus.val_rm_out     = rm_data;
  assign bus.dest_out       = dest;
  assign bus.status_reg     = flags;
  assign bus.carry_out      = flags[FLAG_C];
  assign bus.retire_cnt     = retire;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Directed bench for exe_mem_reg: stimulus pushes hand-computed expectations
// into a scoreboard queue, a separate monitor pops and compares each cycle.
module tb_exe_mem_reg;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  exe_mem_reg_if bus ();

  exe_mem_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ctl = {rst, valid_in, s_bit, wb_en_in, mem_r_en_in, mem_w_en_in, freeze, flush}
  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] alu;
    logic [3:0]  st;
    logic [3:0]  dest;
    logic [31:0] rm;
    logic [3:0]  cond;
  } stim_t;

  // ctl = {valid_out, wb_en, mem_r_en, mem_w_en}
  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic [31:0] alu;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic [3:0]  status;
    logic [31:0] cnt;
    logic        cp;
    logic        dchk;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic cp_seen;

  function automatic stim_t mk(input logic [7:0] ctl, input logic [31:0] alu,
                               input logic [3:0] st, input logic [3:0] dest,
                               input logic [31:0] rm, input logic [3:0] cond);
    stim_t s;
    s.ctl = ctl; s.alu = alu; s.st = st; s.dest = dest; s.rm = rm; s.cond = cond;
    return s;
  endfunction

  function automatic exp_t ex(input string nm, input logic [3:0] ctl,
                              input logic [31:0] alu, input logic [31:0] rm,
                              input logic [3:0] dest, input logic [3:0] status,
                              input logic [31:0] cnt, input logic cp, input logic dchk);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.alu = alu; e.rm = rm; e.dest = dest;
    e.status = status; e.cnt = cnt; e.cp = cp; e.dchk = dchk;
    return e;
  endfunction

  task automatic drive(input stim_t s, input exp_t e);
    @(negedge clk);
    rst             = s.ctl[7];
    bus.valid_in    = s.ctl[6];
    bus.s_bit       = s.ctl[5];
    bus.wb_en_in    = s.ctl[4];
    bus.mem_r_en_in = s.ctl[3];
    bus.mem_w_en_in = s.ctl[2];
    bus.freeze      = s.ctl[1];
    bus.flush       = s.ctl[0];
    bus.alu_result  = s.alu;
    bus.status_bits = s.st;
    bus.dest_in     = s.dest;
    bus.val_rm_in   = s.rm;
    bus.cond_in     = s.cond;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: cond_pass is sampled mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      cp_seen = bus.cond_pass;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, "cond_pass", 32'(cp_seen), 32'(e.cp));
        chk(e.name, "valid_out", 32'(bus.valid_out), 32'(e.ctl[3]));
        chk(e.name, "wb_en", 32'(bus.wb_en), 32'(e.ctl[2]));
        chk(e.name, "mem_r_en", 32'(bus.mem_r_en), 32'(e.ctl[1]));
        chk(e.name, "mem_w_en", 32'(bus.mem_w_en), 32'(e.ctl[0]));
        chk(e.name, "status_reg", 32'(bus.status_reg), 32'(e.status));
        chk(e.name, "carry_out", 32'(bus.carry_out), 32'(e.status[1]));
        chk(e.name, "retire_cnt", bus.retire_cnt, e.cnt);
        if (e.dchk) begin
          chk(e.name, "alu_result_out", bus.alu_result_out, e.alu);
          chk(e.name, "val_rm_out", bus.val_rm_out, e.rm);
          chk(e.name, "dest_out", 32'(bus.dest_out), 32'(e.dest));
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus.valid_in = 1'b0; bus.s_bit = 1'b0; bus.wb_en_in = 1'b0;
    bus.mem_r_en_in = 1'b0; bus.mem_w_en_in = 1'b0; bus.freeze = 1'b0;
    bus.flush = 1'b0; bus.alu_result = 32'h0; bus.status_bits = 4'h0;
    bus.dest_in = 4'h0; bus.val_rm_in = 32'h0; bus.cond_in = 4'h0;

    // Reset state
    drive(mk(8'b0_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b1110),
          ex("rst_al", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000, 32'd0, 1'b1, 1'b1));
    drive(mk(8'b0_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b0000),
          ex("rst_eq", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000, 32'd0, 1'b0, 1'b1));

    // Flag bypass on the committing cycle, flush squash, plain load, store
    drive(mk(8'b1_1_1_1_0_0_0_0, 32'h0000_1234, 4'b0100, 4'd3, 32'hAAAA_5555, 4'b0000),
          ex("commit_sbit", 4'b1100, 32'h0000_1234, 32'hAAAA_5555, 4'd3, 4'b0100, 32'd1, 1'b1, 1'b1));
    drive(mk(8'b1_1_1_1_1_0_0_1, 32'h0000_9999, 4'b0010, 4'd4, 32'h1, 4'b0010),
          ex("flush", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0100, 32'd1, 1'b0, 1'b0));
    drive(mk(8'b1_1_0_0_1_0_0_0, 32'h0000_0100, 4'b1111, 4'd5, 32'h0, 4'b0001),
          ex("load_noflags", 4'b1010, 32'h0000_0100, 32'h0, 4'd5, 4'b0100, 32'd2, 1'b0, 1'b1));
    drive(mk(8'b1_1_1_0_0_1_0_0, 32'h0000_0010, 4'b0011, 4'd7, 32'hDEAD_BEEF, 4'b1000),
          ex("store_flags", 4'b1001, 32'h0000_0010, 32'hDEAD_BEEF, 4'd7, 4'b0011, 32'd3, 1'b1, 1'b1));
    drive(mk(8'b1_0_1_1_0_0_0_0, 32'h55, 4'b1000, 4'd8, 32'h66, 4'b0110),
          ex("bubble", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0011, 32'd3, 1'b1, 1'b0));

    // Freeze wins over flush and new inputs for three cycles, then release
    drive(mk(8'b1_1_0_1_0_0_0_0, 32'hCAFE_0001, 4'b0000, 4'd9, 32'h1357_9BDF, 4'b1110),
          ex("pre_freeze", 4'b1100, 32'hCAFE_0001, 32'h1357_9BDF, 4'd9, 4'b0011, 32'd4, 1'b1, 1'b1));
    drive(mk(8'b1_1_1_0_1_1_1_1, 32'hFFFF_FFFF, 4'b1111, 4'hF, 32'h0, 4'b0000),
          ex("freeze1", 4'b1100, 32'hCAFE_0001, 32'h1357_9BDF, 4'd9, 4'b0011, 32'd4, 1'b0, 1'b1));
    drive(mk(8'b1_1_1_0_1_1_1_1, 32'hFFFF_FFFF, 4'b1111, 4'hF, 32'h0, 4'b0010),
          ex("freeze2", 4'b1100, 32'hCAFE_0001, 32'h1357_9BDF, 4'd9, 4'b0011, 32'd4, 1'b1, 1'b1));
    drive(mk(8'b1_1_1_0_1_1_1_1, 32'hFFFF_FFFF, 4'b1111, 4'hF, 32'h0, 4'b1011),
          ex("freeze3", 4'b1100, 32'hCAFE_0001, 32'h1357_9BDF, 4'd9, 4'b0011, 32'd4, 1'b1, 1'b1));
    drive(mk(8'b1_1_1_1_0_0_0_0, 32'h0000_0042, 4'b1001, 4'd2, 32'h0000_0024, 4'b1010),
          ex("unfreeze", 4'b1100, 32'h0000_0042, 32'h0000_0024, 4'd2, 4'b1001, 32'd5, 1'b1, 1'b1));

    // Condition sweep with status_reg = 1001 (N=1, Z=0, C=0, V=1)
    drive(mk(8'b1_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b1010),
          ex("cond_ge", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b1001, 32'd5, 1'b1, 1'b0));
    drive(mk(8'b1_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b1011),
          ex("cond_lt", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b1001, 32'd5, 1'b0, 1'b0));
    drive(mk(8'b1_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b1100),
          ex("cond_gt", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b1001, 32'd5, 1'b1, 1'b0));
    drive(mk(8'b1_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b1101),
          ex("cond_le", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b1001, 32'd5, 1'b0, 1'b0));
    drive(mk(8'b1_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b0100),
          ex("cond_mi", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b1001, 32'd5, 1'b1, 1'b0));
    drive(mk(8'b1_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b0101),
          ex("cond_pl", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b1001, 32'd5, 1'b0, 1'b0));
    drive(mk(8'b1_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b1001),
          ex("cond_ls", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b1001, 32'd5, 1'b1, 1'b0));
    drive(mk(8'b1_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b0011),
          ex("cond_cc", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b1001, 32'd5, 1'b1, 1'b0));
    drive(mk(8'b1_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b1111),
          ex("cond_nv", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b1001, 32'd5, 1'b0, 1'b0));

    // Reset asserted mid-freeze/flush clears at once, then first edge behaves normally
    drive(mk(8'b0_1_1_1_1_1_1_1, 32'h77, 4'b1111, 4'hE, 32'h88, 4'b0101),
          ex("rst_mid", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000, 32'd0, 1'b1, 1'b1));
    drive(mk(8'b0_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b0000),
          ex("rst_eq2", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000, 32'd0, 1'b0, 1'b1));
    drive(mk(8'b1_1_1_1_0_0_0_0, 32'h7, 4'b0001, 4'd1, 32'h8, 4'b0111),
          ex("post_rst", 4'b1100, 32'h7, 32'h8, 4'd1, 4'b0001, 32'd1, 1'b0, 1'b1));

    // Saturation: preload the counter to FFFFFFFE through its next-state net
    drive(mk(8'b1_0_0_0_0_0_0_0, 32'h0, 4'h0, 4'h0, 32'h0, 4'b1110),
          ex("cnt_preset", 4'b0000, 32'h0, 32'h0, 4'h0, 4'b0001, 32'hFFFF_FFFE, 1'b1, 1'b0));
    force dut.retire_nxt = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.retire_nxt;
    drive(mk(8'b1_1_0_1_0_0_0_0, 32'h1, 4'h0, 4'd10, 32'h0, 4'b1110),
          ex("sat1", 4'b1100, 32'h1, 32'h0, 4'd10, 4'b0001, 32'hFFFF_FFFF, 1'b1, 1'b1));
    drive(mk(8'b1_1_0_1_0_0_0_0, 32'h2, 4'h0, 4'd10, 32'h0, 4'b1110),
          ex("sat2", 4'b1100, 32'h2, 32'h0, 4'd10, 4'b0001, 32'hFFFF_FFFF, 1'b1, 1'b1));
    drive(mk(8'b1_1_0_1_0_0_0_0, 32'h3, 4'h0, 4'd10, 32'h0, 4'b1110),
          ex("sat3", 4'b1100, 32'h3, 32'h0, 4'd10, 4'b0001, 32'hFFFF_FFFF, 1'b1, 1'b1));

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_mem_reg.md
EXE_MEM_REG -- requirements
Module: exe_mem_reg

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: valid_in  in  1  EXE slot holds a real instruction, not a bubble.
REQ-004 SHALL have ports: alu_result  in  32  ALU result; status_bits  in  4  ALU {N,Z,C,V}; s_bit  in  1  instruction sets flags.
REQ-005 SHALL have ports: wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control; dest_in  in  4  destination register; val_rm_in  in  32  store data.
REQ-006 SHALL have ports: freeze  in  1  hold all state; flush  in  1  squash EXE-slot instruction.
REQ-007 SHALL have ports: cond_in  in  4  condition field of the instruction in ID.
REQ-008 SHALL have ports: wb_en, mem_r_en, mem_w_en, valid_out  out  1 each; alu_result_out, val_rm_out  out  32; dest_out  out  4.
REQ-009 SHALL have ports: status_reg  out  4  registered {N,Z,C,V}; carry_out  out  1  = status_reg[1], feeds ALU carry_in.
REQ-010 SHALL have ports: cond_pass  out  1  ID instruction condition satisfied; retire_cnt  out  32  committed-instruction count.

Function
REQ-011 SHALL define commit = valid_in & ~freeze & ~flush, evaluated each cycle.
REQ-012 SHALL, on a rising edge with freeze=0, load all pipeline outputs from inputs (latency 1 cycle), with valid_out, wb_en, mem_r_en, mem_w_en forced to 0 when flush=1 or valid_in=0.
REQ-013 SHALL hold every register, status_reg and retire_cnt unchanged while freeze=1; freeze takes priority over flush.
REQ-014 SHALL load status_reg from status_bits on an edge only when commit & s_bit; otherwise hold.
REQ-015 SHALL compute cond_pass combinationally from next-state flags: status_bits when commit & s_bit, else status_reg (bypass, no bubble needed).
REQ-016 SHALL decode cond: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-017 SHALL increment retire_cnt by 1 on each edge with commit=1, saturating at 32'hFFFFFFFF (no wrap).
REQ-018 SHALL pass alu_result, val_rm_in, dest_in unmodified; data fields of squashed slots are don't-care.

Reset
REQ-019 SHALL, while rst=0, immediately clear all outputs' registers: controls, valid_out, data, dest_out, status_reg = 4'b0000, retire_cnt = 0.
REQ-020 SHALL, on reset mid-freeze or mid-flush, still clear everything; first post-reset edge behaves per REQ-012..017.

Structure
REQ-021 SHALL take condition-code constants (EQ..NV) and flag-bit indices (N=3,Z=2,C=1,V=0) from shared package arm_pkg.
REQ-022 SHALL implement REQ-016 in one combinational sub-module cond_check (inputs cond, flags; output pass).
REQ-023 SHALL contain no other sub-modules; target 120-250 lines.

Verification
REQ-024 Reset asserted mid-stream -> all outputs 0, status_reg=0000, cond_in=1110 gives cond_pass=1, cond_in=0000 gives 0.
REQ-025 valid_in=1, s_bit=1, status_bits=0100, cond_in=0000 same cycle -> cond_pass=1 before edge; after edge status_reg=0100, retire_cnt=1.
REQ-026 s_bit=1, status_bits=0010, flush=1 -> status_reg unchanged, wb_en=0, valid_out=0, retire_cnt unchanged.
REQ-027 freeze=1 with flush=1 and new inputs for 3 cycles -> all outputs, status_reg, retire_cnt constant; release -> load on next edge.
REQ-028 Force retire_cnt to FFFFFFFE, commit three times -> FFFFFFFF, FFFFFFFF, FFFFFFFF.
REQ-029 status_reg=1001 (N=1,V=1), sweep cond 1010/1011/1100/1101 -> cond_pass 1/0/1/0; carry_out=0.
